// File: rtl/param_sorter.sv
// param_sorter: streaming odd-even transposition sorter.
//   Loads up to DEPTH words over an input valid/ready stream, sorts them in place
//   (ascending or descending, signed or unsigned keys, stable), then drains them
//   over an output valid/ready stream.
// Ports:
//   clk, reset (synchronous, active-low)
//   in_valid/in_ready/in_data/in_last/descend : load stream, order sampled on first word
//   out_valid/out_ready/out_data/out_last     : drain stream, out_last on final word
//   busy  : high while sorting or draining
//   count : words held in the current batch
module param_sorter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned SIGNED = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  input  logic                         descend,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      phase_q, phase_d;
  logic [CW-1:0]      rd_q, rd_d;
  logic               ord_q, ord_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [WIDTH-1:0]   slot_q [DEPTH];
  logic [WIDTH-1:0]   slot_d [DEPTH];

  logic [CW-1:0]      rd_sel;
  logic [WIDTH-1:0]   rd_word;

  // Strict greater-than under the configured signedness.
  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) gt = $signed(a) > $signed(b);
    else             gt = a > b;
  endfunction

  // Slot to present next: the current index when priming, the following one on a handshake.
  always_comb begin
    rd_sel  = out_valid_q ? (rd_q + CW'(1)) : rd_q;
    rd_word = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CW'(i) == rd_sel) rd_word = slot_q[i];
    end
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= LOAD;
      count_q     <= '0;
      phase_q     <= '0;
      rd_q        <= '0;
      ord_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      phase_q     <= phase_d;
      rd_q        <= rd_d;
      ord_q       <= ord_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage holds no reset value; a new batch always overwrites what it reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= slot_d[i];
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    phase_d     = phase_q;
    rd_d        = rd_q;
    ord_d       = ord_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    for (int i = 0; i < int'(DEPTH); i++) slot_d[i] = slot_q[i];

    unique case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            if (CW'(i) == count_q) slot_d[i] = in_data;
          end
          count_d = count_q + CW'(1);
          if (count_q == '0) ord_d = descend;
          if (count_d == CW'(DEPTH) || in_last) begin
            state_d = SORT;
            phase_d = '0;
          end
        end
      end

      SORT: begin
        // Active pairs in one phase never overlap, so each slot is written at most once.
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          if ((i % 2) == int'(phase_q[0]) && (i + 1) < int'(count_q)) begin
            if (ord_q ? gt(slot_q[i+1], slot_q[i]) : gt(slot_q[i], slot_q[i+1])) begin
              slot_d[i]   = slot_q[i+1];
              slot_d[i+1] = slot_q[i];
            end
          end
        end
        phase_d = phase_q + CW'(1);
        if (phase_q == count_q - CW'(1)) begin
          state_d = DRAIN;
          rd_d    = '0;
        end
      end

      DRAIN: begin
        if (!out_valid_q) begin
          // First cycle of the drain primes the output register with slot 0.
          out_valid_d = 1'b1;
          out_data_d  = rd_word;
          out_last_d  = (rd_sel == count_q - CW'(1));
        end else if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            count_d     = '0;
            state_d     = LOAD;
          end else begin
            rd_d       = rd_sel;
            out_data_d = rd_word;
            out_last_d = (rd_sel == count_q - CW'(1));
          end
        end
      end

      default: state_d = LOAD;
    endcase
  end

  assign in_ready_d = (state_d == LOAD);
  assign busy_d     = (state_d != LOAD);

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule
